freq_gate_ctrl: RTL
===================

# freq_gate_ctrl

Measurement sequencer for the frequency meter. It drives the BCD edge counter's clear (`cnt_clean`) and enable (`cnt_en`) inputs from the reference clock, opening a precise gate window of 1 s, 100 ms, 10 ms or 1 ms. After each gate it latches the 4-digit BCD count together with an overflow flag and the active range. In auto mode it adapts the range between measurements; results feed the display block.

## Interface
- `CLK_HZ`, default 50_000_000: reference clock frequency in Hz. Must be divisible by 1000.
- `CLR_CYC`, default 2: number of cycles `cnt_clean` is held low before each gate.
- `SETTLE_CYC`, default 4: cycles between gate close and latch.

- `clk` in 1: reference clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: single-measurement request. Ignored while `busy`=1.
- `run` in 1: continuous mode. While high, measurements repeat back-to-back.
- `auto` in 1: 1 = auto-range; 0 = use `range_sel`.
- `range_sel` in 2: manual range. Gate length = CLK_HZ/10^range_sel cycles.
- `cnt` in 16: BCD count from the edge counter (sigin domain).
- `cnt_clean` out 1: active-low counter clear.
- `cnt_en` out 1: gate; counter counts while high.
- `result` out 16: latched BCD count.
- `range` out 2: range of the latest `result`. Result in Hz = result × 10^range.
- `ovf` out 1: the latest result wrapped past 9999.
- `valid` out 1: one-cycle pulse when `result`/`range`/`ovf` update.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE → CLEAR when `start` or `run` is high.
  - CLEAR lasts CLR_CYC cycles, then → GATE.
  - GATE lasts N cycles, then → SETTLE.
  - SETTLE lasts SETTLE_CYC cycles, then → LATCH.
  - LATCH lasts 1 cycle, then → CLEAR if `run` is high, else → IDLE.
- Outputs per state:
  - `cnt_clean`=0 only in CLEAR.
  - `cnt_en`=1 only in GATE.
- Gate range selection: the gate range is fixed on entry to CLEAR.
  - Manual mode: `range_sel`.
  - Auto mode: the internal next-range register.
  - N = CLK_HZ / 10^r.
- Overflow detection:
  - `cnt[15]` (MSD ≥ 8) is passed through a 2-FF synchronizer.
  - During GATE, the block records that bit as high (seen_hi).
  - A subsequent 1→0 transition of the synchronized bit sets the sticky `ovf_pend` flag (wrap 9999→0000).
  - Both flags clear in CLEAR.
- LATCH actions:
  - result ← cnt (stable: the gate is closed, settle time has elapsed).
  - ovf ← ovf_pend; range ← gate range; valid=1.
- Auto-range update (in LATCH):
  - If ovf_pend and r<3: next ← r+1.
  - Else if `cnt[15:12]`==0 and r>0: next ← r−1.
  - Else next ← r.
  - No oscillation: a result below 1000 read one range lower stays ≤9999.
- The result is always published, including when `ovf`=1.
- `run` falling mid-measurement: the current measurement completes and publishes, then the block goes to IDLE.
- `start` and `run` both high: behaves as `run`.
- Changes to `range_sel` or `auto` mid-measurement take effect at the next CLEAR.

## Timing
- Reset values: `cnt_clean`=1, `cnt_en`=0, `result`=0, `range`=0, `ovf`=0, `valid`=0, `busy`=0, next-range=0, state=IDLE.
- Reset mid-gate: `cnt_en` drops asynchronously.
- All outputs are registered.
- With `start` sampled at edge 0:
  - `cnt_clean` is low in cycles 1..CLR_CYC.
  - `cnt_en` is high for exactly N cycles.
  - `valid` is high in cycle CLR_CYC+N+SETTLE_CYC+2 (= N+8 with defaults).
- Continuous mode: the period is CLR_CYC+N+SETTLE_CYC+1 cycles.
- Counting accuracy: ±1 count, from sigin/gate phase.

## Structure
- Shared package (`freq_meter_pkg` include), holding:
  - state encodings;
  - range constants RANGE_1S..RANGE_1MS;
  - a function giving gate length per range.
- Sub-module `gate_timer`:
  - loadable down-counter of width ceil(log2(CLK_HZ+1)), 26 bits at the default;
  - `done` pulse at terminal count;
  - reused for the CLEAR, GATE and SETTLE durations.
- Top level holds the FSM, the synchronizer, the overflow tracker and the auto-range logic.

## Test plan
The bench uses CLK_HZ=40_000, giving gates of 40000/4000/400/40 cycles; sigin is modelled with the real counter.
- Reset check: assert `rst`, then release → all outputs at reset values; `busy`=0; no `valid` without `start`.
- Single measurement: `start` pulse, `auto`=0, `range_sel`=0, sigin period 16 clk → `result`=16'h2500 (±1); `range`=0; `ovf`=0; `valid` exactly 40008 cycles after `start` is sampled, one cycle wide.
- Auto-range up: `auto`=1, `run`=1, sigin period 2 clk:
  - first result at range 0 with `ovf`=1;
  - next result 16'h2000, `range`=1, `ovf`=0;
  - stays at range 1.
- Auto-range down: at range 1, sigin period 400 clk → result 16'h0010; next measurement at range 0 → 16'h0100.
- Stop and reset: `run` deasserted mid-gate → that measurement publishes, then IDLE. Reset asserted mid-gate → `cnt_en`=0 immediately, state IDLE.
- Manual range 3: `range_sel`=3, sigin period 8 clk → gate 40 cycles, `result`=16'h0005 (±1), `range`=3.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: sequencer state encoding,
// gate range codes and the gate length (in reference clocks) per range.
package freq_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4
    } state_t;

    // Range r means a gate of 10^-r seconds; result in Hz = count * 10^r.
    localparam logic [1:0] RANGE_1S    = 2'd0;
    localparam logic [1:0] RANGE_100MS = 2'd1;
    localparam logic [1:0] RANGE_10MS  = 2'd2;
    localparam logic [1:0] RANGE_1MS   = 2'd3;

    // Gate length in reference clock cycles. clk_hz is always a parameter,
    // so this reduces to a 4-way mux of constants.
    function automatic int unsigned gate_len(input int unsigned clk_hz,
                                             input logic [1:0]  rng);
        case (rng)
            RANGE_1S:    return clk_hz;
            RANGE_100MS: return clk_hz / 10;
            RANGE_10MS:  return clk_hz / 100;
            default:     return clk_hz / 1000;
        endcase
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter timing the CLEAR, GATE and SETTLE phases.
// Ports:
//   i_clk, i_rst   clock, async active-low reset
//   i_load, i_val  load i_val (= phase length - 1) into the counter
//   o_done         terminal count reached (counter at zero)
module gate_timer
    import freq_meter_pkg::*;
#(
    parameter int W = 26
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    // The owner reloads on the same edge it sees done, so within a timed
    // phase this is high for exactly the last cycle.
    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer for the frequency meter. Clears the BCD edge
// counter, opens a gate of 1 s / 100 ms / 10 ms / 1 ms, lets the count
// settle, then latches result, overflow and range. Auto mode steps the
// range up on overflow and down when the leading digit is zero.
// Ports:
//   i_clk, i_rst            reference clock, async active-low reset
//   i_start / i_run         single / continuous measurement request
//   i_auto, i_range_sel     auto-range enable, manual range
//   i_cnt                   BCD count from the edge counter (sigin domain)
//   o_cnt_clean, o_cnt_en   counter clear (active low) and gate
//   o_result/o_range/o_ovf  latched measurement, o_valid one-cycle update strobe
//   o_busy                  sequencer not idle
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int CLR_CYC    = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_run,
    input  logic        i_auto,
    input  logic [1:0]  i_range_sel,
    input  logic [15:0] i_cnt,
    output logic        o_cnt_clean,
    output logic        o_cnt_en,
    output logic [15:0] o_result,
    output logic [1:0]  o_range,
    output logic        o_ovf,
    output logic        o_valid,
    output logic        o_busy
);

    localparam int TW = $clog2(CLK_HZ + 1);

    state_t        r_state;
    logic [1:0]    r_rng;        // range of the measurement in flight
    logic [1:0]    r_next;       // auto-range choice for the next measurement
    logic          r_msd_s1, r_msd_s2;
    logic          r_seen_hi, r_ovf_pend;

    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_done;
    logic [1:0]    w_next_upd;
    logic [1:0]    w_rng_new;

    gate_timer #(.W(TW)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .o_done (w_tmr_done)
    );

    // Auto-range decision from the count being latched. A reading below
    // 1000 shown one range lower is at most 9999, so stepping down never
    // causes an immediate overflow back up.
    always_comb begin
        w_next_upd = r_rng;
        if (r_ovf_pend && r_rng != RANGE_1MS)
            w_next_upd = r_rng + 2'd1;
        else if (i_cnt[15:12] == 4'd0 && r_rng != RANGE_1S)
            w_next_upd = r_rng - 2'd1;
    end

    // Range fixed on entry to CLEAR. Coming from LATCH the auto choice must
    // be the one being computed right now, not the stale register.
    always_comb begin
        w_rng_new = i_range_sel;
        if (i_auto)
            w_rng_new = (r_state == ST_LATCH) ? w_next_upd : r_next;
    end

    // Timer is loaded with (length - 1) on the edge that enters each phase.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: if (i_start || i_run) begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TW'(CLR_CYC - 1);
            end
            ST_CLEAR: if (w_tmr_done) begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TW'(gate_len(CLK_HZ, r_rng) - 1);
            end
            ST_GATE: if (w_tmr_done) begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TW'(SETTLE_CYC - 1);
            end
            ST_LATCH: if (i_run) begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TW'(CLR_CYC - 1);
            end
            default: ;
        endcase
    end

    // cnt[15] (MSD >= 8) into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_msd_s1 <= 1'b0;
            r_msd_s2 <= 1'b0;
        end else begin
            r_msd_s1 <= i_cnt[15];
            r_msd_s2 <= r_msd_s1;
        end
    end

    // Overflow = MSD seen high, then seen low again (9999 -> 0000 wrap).
    // Tracking continues through SETTLE to cover the synchronizer latency
    // for a wrap right at the end of the gate.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_seen_hi  <= 1'b0;
            r_ovf_pend <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_seen_hi  <= 1'b0;
            r_ovf_pend <= 1'b0;
        end else if (r_state == ST_GATE || r_state == ST_SETTLE) begin
            if (r_msd_s2)
                r_seen_hi <= 1'b1;
            else if (r_seen_hi)
                r_ovf_pend <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_rng       <= RANGE_1S;
            r_next      <= RANGE_1S;
            o_cnt_clean <= 1'b1;
            o_cnt_en    <= 1'b0;
            o_result    <= '0;
            o_range     <= RANGE_1S;
            o_ovf       <= 1'b0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (i_start || i_run) begin
                    r_state     <= ST_CLEAR;
                    r_rng       <= w_rng_new;
                    o_cnt_clean <= 1'b0;
                    o_busy      <= 1'b1;
                end
                ST_CLEAR: if (w_tmr_done) begin
                    r_state     <= ST_GATE;
                    o_cnt_clean <= 1'b1;
                    o_cnt_en    <= 1'b1;
                end
                ST_GATE: if (w_tmr_done) begin
                    r_state  <= ST_SETTLE;
                    o_cnt_en <= 1'b0;
                end
                ST_SETTLE: if (w_tmr_done)
                    r_state <= ST_LATCH;
                ST_LATCH: begin
                    o_result <= i_cnt;
                    o_ovf    <= r_ovf_pend;
                    o_range  <= r_rng;
                    o_valid  <= 1'b1;
                    r_next   <= w_next_upd;
                    if (i_run) begin
                        r_state     <= ST_CLEAR;
                        r_rng       <= w_rng_new;
                        o_cnt_clean <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
